// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues one in-order fetch at a time from the PC register
// value, captures the returned word into a single output register, and handles redirects.
module ifetch_unit #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_addr,
    input  logic        redirect,
    output logic        pc_enable,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        if_misaligned,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_req_pc;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [63:0] r_if_pc;
    logic        r_if_misaligned;

    logic        w_out_free;
    logic        w_aligned;
    logic        w_req_valid;
    logic        w_handshake;
    logic        w_load_fetch;
    logic        w_load_fault;

    assign w_out_free  = !r_if_valid || id_ready;
    assign w_aligned   = (pc_addr[1:0] == 2'b00);
    assign w_handshake = w_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_valid  = 1'b0;
        w_load_fetch = 1'b0;
        w_load_fault = 1'b0;
        case (r_state)
            S_REQ: begin
                if (!redirect && w_out_free) begin
                    if (w_aligned) begin
                        w_req_valid = 1'b1;
                        if (imem_req_ready) begin
                            w_state_next = S_WAIT;
                        end
                    end else begin
                        w_load_fault = 1'b1;
                        w_state_next = S_HALT;
                    end
                end
            end
            S_WAIT: begin
                // A response landing together with a redirect is stale but still
                // retires the outstanding fetch, so there is nothing left to drop.
                if (redirect) begin
                    w_state_next = imem_resp_valid ? S_REQ : S_DROP;
                end else if (imem_resp_valid) begin
                    w_load_fetch = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) begin
                    w_state_next = S_REQ;
                end
            end
            S_HALT: begin
                if (redirect) begin
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase
        if (reset) begin
            w_req_valid  = 1'b0;
            w_load_fetch = 1'b0;
            w_load_fault = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_pc <= 64'd0;
        end else if (w_handshake) begin
            r_req_pc <= pc_addr;
        end
    end

    // Output register: loads have priority over the consume-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_valid      <= 1'b0;
            r_if_instr      <= RESET_INSTR;
            r_if_pc         <= 64'd0;
            r_if_misaligned <= 1'b0;
        end else if (redirect) begin
            r_if_valid <= 1'b0;
        end else if (w_load_fault) begin
            r_if_valid      <= 1'b1;
            r_if_instr      <= RESET_INSTR;
            r_if_pc         <= pc_addr;
            r_if_misaligned <= 1'b1;
        end else if (w_load_fetch) begin
            r_if_valid      <= 1'b1;
            r_if_instr      <= imem_resp_data;
            r_if_pc         <= r_req_pc;
            r_if_misaligned <= 1'b0;
        end else if (r_if_valid && id_ready) begin
            r_if_valid <= 1'b0;
        end
    end

    assign pc_enable      = !reset && (redirect || w_handshake);
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = pc_addr;
    assign if_valid       = r_if_valid;
    assign if_instr       = r_if_instr;
    assign if_pc          = r_if_pc;
    assign if_misaligned  = r_if_misaligned;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: models the PC register and a variable-latency instruction
// memory, then runs directed scenarios and a randomized stream against a scoreboard.
module tb_ifetch_unit;

    logic        clk;
    logic        reset;
    logic [63:0] pc_addr;
    logic        redirect;
    logic        pc_enable;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_misaligned;
    logic        id_ready;

    logic [63:0] redir_target;
    int          mem_lat;
    logic        mem_pend;
    int          mem_cnt;
    logic [63:0] mem_addr;
    int          total;
    int          bad;

    ifetch_unit #(.RESET_INSTR(32'h0000_0013)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_addr        (pc_addr),
        .redirect       (redirect),
        .pc_enable      (pc_enable),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_misaligned  (if_misaligned),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: the PC register and memory react to what was visible before the edge.
    task automatic tick();
        logic        acc;
        logic        pe;
        logic        rd;
        logic [63:0] a;
        logic [63:0] tgt;
        #1;
        acc = imem_req_valid && imem_req_ready;
        pe  = pc_enable;
        rd  = redirect;
        a   = imem_req_addr;
        tgt = redir_target;
        @(posedge clk);
        #1;
        if (reset) begin
            pc_addr         = 64'd0;
            mem_pend        = 1'b0;
            imem_resp_valid = 1'b0;
        end else begin
            if (pe) pc_addr = rd ? tgt : pc_addr + 64'd4;
            imem_resp_valid = 1'b0;
            if (acc) begin
                mem_pend = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = a;
            end
            if (mem_pend) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt <= 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(mem_addr);
                    mem_pend        = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        tick();
        tick();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%0b want=0", if_valid); end
        total++; if (if_instr !== 32'h13) begin bad++; $display("FAIL reset_if_instr got=%h want=00000013", if_instr); end
        total++; if (if_pc !== 64'd0) begin bad++; $display("FAIL reset_if_pc got=%h want=0", if_pc); end
        total++; if (if_misaligned !== 1'b0) begin bad++; $display("FAIL reset_if_misaligned got=%0b want=0", if_misaligned); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0b want=0", imem_req_valid); end
        total++; if (pc_enable !== 1'b0) begin bad++; $display("FAIL reset_pc_enable got=%0b want=0", pc_enable); end
        reset = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'd0) begin bad++; $display("FAIL reset_first_req got=%0b/%h want=1/0", imem_req_valid, imem_req_addr); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        mem_lat        = 1;
        for (int k = 0; k < 3; k++) begin
            logic [63:0] a;
            a = 64'(4 * k);
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin bad++; $display("FAIL stream_req got=%0b/%h want=1/%h", imem_req_valid, imem_req_addr, a); end
            total++; if (pc_enable !== 1'b1) begin bad++; $display("FAIL stream_pc_en_accept got=%0b want=1", pc_enable); end
            tick();
            total++; if (imem_req_valid !== 1'b0 || pc_enable !== 1'b0) begin bad++; $display("FAIL stream_wait_idle got=%0b/%0b want=0/0", imem_req_valid, pc_enable); end
            total++; if (pc_addr !== a + 64'd4) begin bad++; $display("FAIL stream_pc_advance got=%h want=%h", pc_addr, a + 64'd4); end
            tick();
            total++; if (if_valid !== 1'b1 || if_pc !== a || if_instr !== mem_word(a)) begin bad++; $display("FAIL stream_out got=%0b/%h/%h want=1/%h/%h", if_valid, if_pc, if_instr, a, mem_word(a)); end
            $display("stream fetch pc=%h instr=%h", if_pc, if_instr);
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        mem_lat        = 1;
        redirect       = 1'b1;
        redir_target   = 64'h10;
        tick();
        redirect = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h10) begin bad++; $display("FAIL stall_req_hold got=%0b/%h want=1/10", imem_req_valid, imem_req_addr); end
            total++; if (pc_enable !== 1'b0) begin bad++; $display("FAIL stall_pc_en got=%0b want=0", pc_enable); end
            tick();
        end
        imem_req_ready = 1'b1;
        #1;
        total++; if (pc_enable !== 1'b1) begin bad++; $display("FAIL stall_accept_pc_en got=%0b want=1", pc_enable); end
        tick();
        total++; if (pc_addr !== 64'h14) begin bad++; $display("FAIL stall_pc_once got=%h want=14", pc_addr); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'h10 || if_instr !== mem_word(64'h10)) begin bad++; $display("FAIL stall_out got=%0b/%h/%h want=1/10/%h", if_valid, if_pc, if_instr, mem_word(64'h10)); end
        total++; if (pc_addr !== 64'h14) begin bad++; $display("FAIL stall_pc_still got=%h want=14", pc_addr); end
        $display("stall fetch pc=%h instr=%h", if_pc, if_instr);
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b0;
        mem_lat        = 1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (if_valid !== 1'b1 || if_pc !== 64'd0 || if_instr !== mem_word(64'd0)) begin bad++; $display("FAIL bp_hold got=%0b/%h/%h want=1/0/%h", if_valid, if_pc, if_instr, mem_word(64'd0)); end
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_no_req got=%0b want=0", imem_req_valid); end
            tick();
        end
        id_ready = 1'b1;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'd4) begin bad++; $display("FAIL bp_release_req got=%0b/%h want=1/4", imem_req_valid, imem_req_addr); end
        tick();
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'd4) begin bad++; $display("FAIL bp_next_out got=%0b/%h want=1/4", if_valid, if_pc); end
        $display("backpressure fetch pc=%h instr=%h", if_pc, if_instr);
    endtask

    task automatic test_redirect_wait();
        logic found;
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        mem_lat        = 2;
        tick();
        redirect     = 1'b1;
        redir_target = 64'h100;
        #1;
        total++; if (pc_enable !== 1'b1 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_outputs got=%0b/%0b want=1/0", pc_enable, imem_req_valid); end
        tick();
        redirect = 1'b0;
        mem_lat  = 1;
        #1;
        total++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_after got=%0b/%0b want=0/0", if_valid, imem_req_valid); end
        tick();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_stale_dropped got=%0b want=0", if_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h100) begin bad++; $display("FAIL redir_new_req got=%0b/%h want=1/100", imem_req_valid, imem_req_addr); end
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (if_valid) begin
                found = 1'b1;
                total++; if (if_pc !== 64'h100 || if_instr !== mem_word(64'h100)) begin bad++; $display("FAIL redir_out got=%h/%h want=100/%h", if_pc, if_instr, mem_word(64'h100)); end
            end
        end
        total++; if (!found) begin bad++; $display("FAIL redir_timeout got=no_valid want=valid"); end
        $display("redirect fetch pc=%h instr=%h", if_pc, if_instr);
    endtask

    task automatic test_misaligned();
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        mem_lat        = 1;
        redirect       = 1'b1;
        redir_target   = 64'h102;
        tick();
        redirect = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0 || pc_enable !== 1'b0) begin bad++; $display("FAIL mis_no_req got=%0b/%0b want=0/0", imem_req_valid, pc_enable); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'h102 || if_misaligned !== 1'b1 || if_instr !== 32'h13) begin bad++; $display("FAIL mis_out got=%0b/%h/%0b/%h want=1/102/1/00000013", if_valid, if_pc, if_misaligned, if_instr); end
        $display("misaligned fault pc=%h", if_pc);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (imem_req_valid !== 1'b0 || pc_enable !== 1'b0) begin bad++; $display("FAIL mis_halt got=%0b/%0b want=0/0", imem_req_valid, pc_enable); end
        end
        redirect     = 1'b1;
        redir_target = 64'h200;
        #1;
        total++; if (pc_enable !== 1'b1) begin bad++; $display("FAIL mis_redir_pc_en got=%0b want=1", pc_enable); end
        tick();
        redirect = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h200) begin bad++; $display("FAIL mis_resume_req got=%0b/%h want=1/200", imem_req_valid, imem_req_addr); end
        tick();
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'h200 || if_misaligned !== 1'b0 || if_instr !== mem_word(64'h200)) begin bad++; $display("FAIL mis_resume_out got=%0b/%h/%0b/%h want=1/200/0/%h", if_valid, if_pc, if_misaligned, if_instr, mem_word(64'h200)); end
        $display("resume fetch pc=%h instr=%h", if_pc, if_instr);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        mem_lat        = 1;
        redirect       = 1'b1;
        redir_target   = 64'h40;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        mem_lat = 3;
        tick();
        total++; if (if_pc !== 64'h40 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL rstw_setup got=%h/%0b want=40/0", if_pc, imem_req_valid); end
        reset = 1'b1;
        #1;
        total++; if (imem_req_valid !== 1'b0 || pc_enable !== 1'b0) begin bad++; $display("FAIL rstw_during got=%0b/%0b want=0/0", imem_req_valid, pc_enable); end
        tick();
        reset = 1'b0;
        #1;
        total++; if (if_valid !== 1'b0 || if_pc !== 64'd0 || if_instr !== 32'h13 || if_misaligned !== 1'b0) begin bad++; $display("FAIL rstw_values got=%0b/%h/%h/%0b want=0/0/00000013/0", if_valid, if_pc, if_instr, if_misaligned); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'd0) begin bad++; $display("FAIL rstw_restart got=%0b/%h want=1/0", imem_req_valid, imem_req_addr); end
        mem_lat = 1;
        tick();
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'd0 || if_instr !== mem_word(64'd0)) begin bad++; $display("FAIL rstw_refetch got=%0b/%h/%h want=1/0/%h", if_valid, if_pc, if_instr, mem_word(64'd0)); end
        $display("reset-in-wait refetch pc=%h instr=%h", if_pc, if_instr);
    endtask

    // Random ready/latency/backpressure: decode must see 0,4,8,... each exactly once.
    task automatic test_random();
        logic [63:0] exp_pc;
        logic        prev_stalled;
        logic [63:0] prev_addr;
        do_reset();
        exp_pc       = 64'd0;
        prev_stalled = 1'b0;
        prev_addr    = 64'd0;
        for (int c = 0; c < 600; c++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            mem_lat        = int'($urandom_range(1, 3));
            #1;
            if (imem_req_valid) begin
                total++; if (imem_req_addr !== pc_addr) begin bad++; $display("FAIL rand_addr got=%h want=%h", imem_req_addr, pc_addr); end
            end
            if (prev_stalled) begin
                total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin bad++; $display("FAIL rand_req_hold got=%0b/%h want=1/%h", imem_req_valid, imem_req_addr, prev_addr); end
            end
            if (if_valid && id_ready) begin
                total++; if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc) || if_misaligned !== 1'b0) begin bad++; $display("FAIL rand_retire got=%h/%h/%0b want=%h/%h/0", if_pc, if_instr, if_misaligned, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 64'd4;
            end
            prev_stalled = imem_req_valid && !imem_req_ready;
            prev_addr    = imem_req_addr;
            tick();
        end
        total++; if (exp_pc < 64'd120) begin bad++; $display("FAIL rand_progress got=%0d want>=30", exp_pc / 4); end
        $display("random stream retired=%0d", exp_pc / 4);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        pc_addr         = 64'd0;
        redirect        = 1'b0;
        redir_target    = 64'd0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        id_ready        = 1'b1;
        mem_lat         = 1;
        mem_pend        = 1'b0;
        mem_cnt         = 0;
        mem_addr        = 64'd0;
        test_reset();
        test_stream();
        test_req_stall();
        test_backpressure();
        test_redirect_wait();
        test_misaligned();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
